// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: splits 64-bit line-read beats into PC-tagged
// 32-bit instructions, buffers them, and raises halt on a zero word.
module instr_fetch_queue #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DEPTH          = 16,
    parameter int BEATS_PER_LINE = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      line_start,
    input  logic [63:0]               line_addr,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic                      bus_respack,
    output logic                      line_done,
    output logic                      out_valid,
    output logic [31:0]               out_instr,
    output logic [63:0]               out_pc,
    input  logic                      out_ready,
    output logic                      halt,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RECV   = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    localparam logic [AW:0]   ROOM_LIMIT = (AW+1)'(DEPTH - 2);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS_PER_LINE - 1);

    logic [1:0]    state;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [BW-1:0] beat_cnt;
    logic [63:0]   pc_next;
    logic          term_seen;

    logic [31:0] instr_mem [DEPTH];
    logic [63:0] pc_mem    [DEPTH];

    logic [31:0] lo_word;
    logic [31:0] hi_word;
    logic        lo_zero;
    logic        hi_zero;
    logic        room;
    logic        ack_recv;
    logic        push_lo;
    logic        push_hi;
    logic        term_beat;
    logic        last_beat;
    logic        pop;

    assign lo_word   = bus_resp[31:0];
    assign hi_word   = bus_resp[63:32];
    assign lo_zero   = (lo_word == 32'd0);
    assign hi_zero   = (hi_word == 32'd0);
    // Room is judged on registered occupancy; a pop this cycle does not help.
    assign room      = (count <= ROOM_LIMIT);
    assign ack_recv  = (state == RECV) && bus_respack;
    assign push_lo   = ack_recv && !lo_zero;
    assign push_hi   = push_lo && !hi_zero;
    assign term_beat = ack_recv && (lo_zero || hi_zero);
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign pop       = out_valid && out_ready;

    assign occupancy = count;
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'd0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : 64'd0;
    assign halt      = (state == HALTED) && (count == '0);

    // Beat acceptance: RECV needs two free slots, DRAIN swallows everything.
    always_comb begin
        bus_respack = 1'b0;
        unique case (state)
            RECV:    bus_respack = bus_respcyc && room;
            DRAIN:   bus_respack = bus_respcyc;
            default: bus_respack = 1'b0;
        endcase
    end

    // Storage write: the high word lands in the slot after the low word.
    always_ff @(posedge clk) begin
        if (push_lo) begin
            instr_mem[wr_ptr] <= lo_word;
            pc_mem[wr_ptr]    <= pc_next;
        end
        if (push_hi) begin
            instr_mem[wr_ptr + AW'(1)] <= hi_word;
            pc_mem[wr_ptr + AW'(1)]    <= pc_next + 64'd4;
        end
    end

    // FIFO pointers and occupancy with simultaneous push and pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_lo) + AW'(push_hi);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_lo) + (AW+1)'(push_hi)
                   - (AW+1)'(pop);
        end
    end

    // Line sequencing: beat counting, PC advance, terminator handling.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            pc_next   <= 64'd0;
            term_seen <= 1'b0;
            line_done <= 1'b0;
        end else begin
            line_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (line_start) begin
                        pc_next  <= line_addr;
                        beat_cnt <= '0;
                        state    <= RECV;
                    end
                end
                RECV: begin
                    if (bus_respack) begin
                        pc_next   <= pc_next + 64'd8;
                        term_seen <= term_seen | term_beat;
                        if (last_beat) begin
                            beat_cnt  <= '0;
                            line_done <= 1'b1;
                            state     <= (term_seen || term_beat) ? HALTED : IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                            if (term_beat)
                                state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus_respack) begin
                        if (last_beat) begin
                            beat_cnt  <= '0;
                            line_done <= 1'b1;
                            state     <= HALTED;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                HALTED: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue: line fill, backpressure,
// terminator/halt, mid-line reset and PC wrap.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        line_start = 1'b0;
    logic [63:0] line_addr = '0;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic        bus_respack;
    logic        line_done;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready = 1'b0;
    logic        halt;
    logic [4:0]  occupancy;

    logic        b_line_start = 1'b0;
    logic [63:0] b_line_addr = '0;
    logic        b_bus_respcyc = 1'b0;
    logic [63:0] b_bus_resp = '0;
    logic        b_bus_respack;
    logic        b_line_done;
    logic        b_out_valid;
    logic [31:0] b_out_instr;
    logic [63:0] b_out_pc;
    logic        b_out_ready = 1'b0;
    logic        b_halt;
    logic [2:0]  b_occupancy;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] beats [8];
    bit          feed_timeout;

    always #5 clk = ~clk;

    instr_fetch_queue #(.BUS_DATA_WIDTH(64), .DEPTH(16), .BEATS_PER_LINE(8)) dut (
        .clk(clk), .reset(reset),
        .line_start(line_start), .line_addr(line_addr),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_respack(bus_respack), .line_done(line_done),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .halt(halt), .occupancy(occupancy)
    );

    instr_fetch_queue #(.BUS_DATA_WIDTH(64), .DEPTH(4), .BEATS_PER_LINE(8)) dut_small (
        .clk(clk), .reset(reset),
        .line_start(b_line_start), .line_addr(b_line_addr),
        .bus_respcyc(b_bus_respcyc), .bus_resp(b_bus_resp),
        .bus_respack(b_bus_respack), .line_done(b_line_done),
        .out_valid(b_out_valid), .out_instr(b_out_instr), .out_pc(b_out_pc),
        .out_ready(b_out_ready), .halt(b_halt), .occupancy(b_occupancy)
    );

    task automatic do_reset();
        reset = 1'b0;
        line_start = 1'b0; bus_respcyc = 1'b0; out_ready = 1'b0;
        b_line_start = 1'b0; b_bus_respcyc = 1'b0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic start_line(input logic [63:0] addr);
        line_start = 1'b1;
        line_addr  = addr;
        @(posedge clk);
        #1 line_start = 1'b0;
    endtask

    task automatic fill_beats(input logic [31:0] base);
        for (int k = 0; k < 8; k++)
            beats[k] = {base + 32'(2*k + 1), base + 32'(2*k)};
    endtask

    task automatic feed_beats(input int n);
        bit acked;
        int guard;
        feed_timeout = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus_respcyc = 1'b1;
            bus_resp    = beats[k];
            acked = 1'b0;
            guard = 0;
            while (!acked && guard < 200) begin
                @(negedge clk);
                acked = bus_respack;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acked) feed_timeout = 1'b1;
        end
        bus_respcyc = 1'b0;
    endtask

    task automatic test_reset();
        bus_respcyc = 1'b1; bus_resp = 64'h1234_5678_9ABC_DEF0; out_ready = 1'b1;
        b_bus_respcyc = 1'b1; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus_respack !== 1'b0) begin n_err++; $display("FAIL rst_ack got=%b want=0", bus_respack); end
        n_cmp++; if (line_done !== 1'b0) begin n_err++; $display("FAIL rst_line_done got=%b want=0", line_done); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL rst_halt got=%b want=0", halt); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL rst_occ got=%0d want=0", occupancy); end
        n_cmp++; if (out_instr !== 32'd0) begin n_err++; $display("FAIL rst_instr got=%h want=0", out_instr); end
        n_cmp++; if (out_pc !== 64'd0) begin n_err++; $display("FAIL rst_pc got=%h want=0", out_pc); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_respack !== 1'b0) begin n_err++; $display("FAIL idle_ack got=%b want=0", bus_respack); end
        n_cmp++; if (b_bus_respack !== 1'b0) begin n_err++; $display("FAIL idle_ack_small got=%b want=0", b_bus_respack); end
        @(posedge clk);
        #1;
        bus_respcyc = 1'b0; out_ready = 1'b0;
        b_bus_respcyc = 1'b0; b_out_ready = 1'b0;
    endtask

    task automatic test_line_fill();
        int got = 0;
        int ld = 0;
        logic [31:0] ei;
        logic [63:0] ep;
        out_ready = 1'b1;
        fill_beats(32'h100);
        start_line(64'h1000);
        fork
            feed_beats(8);
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (line_done) ld++;
                    if (out_valid && out_ready) begin
                        ei = 32'h100 + 32'(got);
                        ep = 64'h1000 + 64'(4*got);
                        n_cmp++; if (out_instr !== ei) begin n_err++; $display("FAIL fill_instr[%0d] got=%h want=%h", got, out_instr, ei); end
                        n_cmp++; if (out_pc !== ep) begin n_err++; $display("FAIL fill_pc[%0d] got=%h want=%h", got, out_pc, ep); end
                        got++;
                    end
                end
            end
        join
        @(posedge clk);
        #1;
        n_cmp++; if (feed_timeout !== 1'b0) begin n_err++; $display("FAIL fill_timeout got=1 want=0"); end
        n_cmp++; if (got !== 16) begin n_err++; $display("FAIL fill_count got=%0d want=16", got); end
        n_cmp++; if (ld !== 1) begin n_err++; $display("FAIL fill_line_done got=%0d want=1", ld); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL fill_occ_end got=%0d want=0", occupancy); end
    endtask

    task automatic test_backpressure();
        int got = 0;
        logic [31:0] ei;
        logic [63:0] ep;
        out_ready = 1'b0;
        fill_beats(32'h100);
        start_line(64'h1000);
        feed_beats(8);
        @(negedge clk);
        n_cmp++; if (feed_timeout !== 1'b0) begin n_err++; $display("FAIL bp_timeout got=1 want=0"); end
        n_cmp++; if (occupancy !== 5'd16) begin n_err++; $display("FAIL bp_occ_full got=%0d want=16", occupancy); end
        n_cmp++; if (line_done !== 1'b1) begin n_err++; $display("FAIL bp_line_done got=%b want=1", line_done); end
        n_cmp++; if (out_instr !== 32'h100) begin n_err++; $display("FAIL bp_head got=%h want=100", out_instr); end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                ei = 32'h100 + 32'(got);
                ep = 64'h1000 + 64'(4*got);
                n_cmp++; if (out_instr !== ei) begin n_err++; $display("FAIL bp_instr[%0d] got=%h want=%h", got, out_instr, ei); end
                n_cmp++; if (out_pc !== ep) begin n_err++; $display("FAIL bp_pc[%0d] got=%h want=%h", got, out_pc, ep); end
                got++;
            end
        end
        @(posedge clk);
        #1;
        n_cmp++; if (got !== 16) begin n_err++; $display("FAIL bp_count got=%0d want=16", got); end
        out_ready = 1'b0;
    endtask

    task automatic test_small_depth();
        b_out_ready = 1'b0;
        b_line_start = 1'b1; b_line_addr = 64'h8000;
        @(posedge clk);
        #1 b_line_start = 1'b0;
        b_bus_respcyc = 1'b1; b_bus_resp = {32'h201, 32'h200};
        @(negedge clk);
        n_cmp++; if (b_bus_respack !== 1'b1) begin n_err++; $display("FAIL sm_ack0 got=%b want=1", b_bus_respack); end
        @(posedge clk);
        #1 b_bus_resp = {32'h203, 32'h202};
        @(negedge clk);
        n_cmp++; if (b_bus_respack !== 1'b1) begin n_err++; $display("FAIL sm_ack1 got=%b want=1", b_bus_respack); end
        @(posedge clk);
        #1 b_bus_resp = {32'h205, 32'h204};
        @(negedge clk);
        n_cmp++; if (b_occupancy !== 3'd4) begin n_err++; $display("FAIL sm_occ_full got=%0d want=4", b_occupancy); end
        n_cmp++; if (b_bus_respack !== 1'b0) begin n_err++; $display("FAIL sm_ack2_full got=%b want=0", b_bus_respack); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (b_bus_respack !== 1'b0) begin n_err++; $display("FAIL sm_ack2_hold got=%b want=0", b_bus_respack); end
        @(posedge clk);
        #1 b_out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (b_bus_respack !== 1'b0) begin n_err++; $display("FAIL sm_ack_popcycle got=%b want=0", b_bus_respack); end
        n_cmp++; if (b_out_instr !== 32'h200) begin n_err++; $display("FAIL sm_head0 got=%h want=200", b_out_instr); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (b_occupancy !== 3'd3) begin n_err++; $display("FAIL sm_occ3 got=%0d want=3", b_occupancy); end
        n_cmp++; if (b_bus_respack !== 1'b0) begin n_err++; $display("FAIL sm_ack_occ3 got=%b want=0", b_bus_respack); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (b_occupancy !== 3'd2) begin n_err++; $display("FAIL sm_occ2 got=%0d want=2", b_occupancy); end
        n_cmp++; if (b_bus_respack !== 1'b1) begin n_err++; $display("FAIL sm_ack_occ2 got=%b want=1", b_bus_respack); end
        n_cmp++; if (b_out_instr !== 32'h202) begin n_err++; $display("FAIL sm_head2 got=%h want=202", b_out_instr); end
        @(posedge clk);
        #1 b_out_ready = 1'b0; b_bus_respcyc = 1'b0;
        @(negedge clk);
        n_cmp++; if (b_occupancy !== 3'd3) begin n_err++; $display("FAIL sm_occ_after got=%0d want=3", b_occupancy); end
        n_cmp++; if (b_out_instr !== 32'h203) begin n_err++; $display("FAIL sm_head3 got=%h want=203", b_out_instr); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_terminator();
        int got = 0;
        int ld = 0;
        bit halt_early = 1'b0;
        logic [31:0] ei;
        logic [63:0] ep;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++)
            beats[k] = {32'h300 + 32'(2*k + 1), 32'h300 + 32'(2*k)};
        beats[3] = {32'h0, 32'hDEAD};
        for (int k = 4; k < 8; k++)
            beats[k] = {32'h999, 32'h998};
        start_line(64'h3000);
        fork
            feed_beats(8);
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (line_done) ld++;
                    if (halt && got < 7) halt_early = 1'b1;
                    if (out_valid && out_ready) begin
                        ei = (got == 6) ? 32'hDEAD : 32'h300 + 32'(got);
                        ep = 64'h3000 + 64'(4*got);
                        n_cmp++; if (out_instr !== ei) begin n_err++; $display("FAIL term_instr[%0d] got=%h want=%h", got, out_instr, ei); end
                        n_cmp++; if (out_pc !== ep) begin n_err++; $display("FAIL term_pc[%0d] got=%h want=%h", got, out_pc, ep); end
                        got++;
                    end
                end
            end
        join
        @(posedge clk);
        #1;
        n_cmp++; if (feed_timeout !== 1'b0) begin n_err++; $display("FAIL term_timeout got=1 want=0"); end
        n_cmp++; if (got !== 7) begin n_err++; $display("FAIL term_count got=%0d want=7", got); end
        n_cmp++; if (ld !== 1) begin n_err++; $display("FAIL term_line_done got=%0d want=1", ld); end
        n_cmp++; if (halt_early !== 1'b0) begin n_err++; $display("FAIL term_halt_early got=1 want=0"); end
        n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL term_halt got=%b want=1", halt); end
        start_line(64'h4000);
        bus_respcyc = 1'b1; bus_resp = {32'h11, 32'h10};
        @(negedge clk);
        n_cmp++; if (bus_respack !== 1'b0) begin n_err++; $display("FAIL halted_ack got=%b want=0", bus_respack); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL halted_occ got=%0d want=0", occupancy); end
        n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL halted_sticky got=%b want=1", halt); end
        @(posedge clk);
        #1 bus_respcyc = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_midline_reset();
        int got = 0;
        logic [31:0] ei;
        logic [63:0] ep;
        do_reset();
        out_ready = 1'b0;
        fill_beats(32'h100);
        start_line(64'h1000);
        feed_beats(4);
        @(negedge clk);
        n_cmp++; if (occupancy !== 5'd8) begin n_err++; $display("FAIL mid_occ8 got=%0d want=8", occupancy); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        bus_respcyc = 1'b1; bus_resp = beats[4];
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got=%b want=0", out_valid); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL mid_occ got=%0d want=0", occupancy); end
        n_cmp++; if (bus_respack !== 1'b0) begin n_err++; $display("FAIL mid_idle_ack got=%b want=0", bus_respack); end
        @(posedge clk);
        #1 bus_respcyc = 1'b0;
        out_ready = 1'b1;
        fill_beats(32'h500);
        start_line(64'h2000);
        fork
            feed_beats(8);
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        ei = 32'h500 + 32'(got);
                        ep = 64'h2000 + 64'(4*got);
                        n_cmp++; if (out_instr !== ei) begin n_err++; $display("FAIL mid_instr[%0d] got=%h want=%h", got, out_instr, ei); end
                        n_cmp++; if (out_pc !== ep) begin n_err++; $display("FAIL mid_pc[%0d] got=%h want=%h", got, out_pc, ep); end
                        got++;
                    end
                end
            end
        join
        @(posedge clk);
        #1;
        n_cmp++; if (got !== 16) begin n_err++; $display("FAIL mid_count got=%0d want=16", got); end
        out_ready = 1'b0;
    endtask

    task automatic test_pc_wrap();
        int got = 0;
        logic [31:0] ei;
        logic [63:0] ep;
        out_ready = 1'b1;
        fill_beats(32'h600);
        start_line(64'hFFFF_FFFF_FFFF_FFF8);
        fork
            feed_beats(2);
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        ei = 32'h600 + 32'(got);
                        ep = 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4*got);
                        n_cmp++; if (out_instr !== ei) begin n_err++; $display("FAIL wrap_instr[%0d] got=%h want=%h", got, out_instr, ei); end
                        n_cmp++; if (out_pc !== ep) begin n_err++; $display("FAIL wrap_pc[%0d] got=%h want=%h", got, out_pc, ep); end
                        got++;
                    end
                end
            end
        join
        @(posedge clk);
        #1;
        n_cmp++; if (got !== 4) begin n_err++; $display("FAIL wrap_count got=%0d want=4", got); end
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line_fill();
        test_backpressure();
        test_small_depth();
        test_terminator();
        test_midline_reset();
        test_pc_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
